// File: rtl/pwm_multi_channel_if.sv
// Register-write bus from the SPI register file into the PWM block.
// One-cycle strobe wr_en writes wr_duty into the pending duty of channel wr_ch.
//   wr_en   : write strobe
//   wr_ch   : target channel index
//   wr_duty : duty value
interface pwm_multi_channel_if #(
  parameter int NUM_CH = 16,
  parameter int RES    = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [RES-1:0]  wr_duty;

  modport master (output wr_en, wr_ch, wr_duty);
  modport slave  (input  wr_en, wr_ch, wr_duty);
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with double-buffered per-channel duty.
// A prescaler produces a base tick every prescale+1 clocks; a shared period
// counter runs 0..2^RES-2 on ticks. Duty writes land in a pending register
// and are copied to the active register only when the period counter wraps,
// so no channel ever sees a duty change mid-period.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   en_out       : per-channel output enable
//   en_pwm       : per-channel PWM mode (0 = static high when enabled)
//   wr_bus       : duty write port (wr_en / wr_ch / wr_duty)
//   prescale     : base-tick divider
//   period_start : one-cycle pulse after the tick that wraps the counter
//   out          : registered channel outputs
module pwm_multi_channel #(
  parameter int NUM_CH  = 16,
  parameter int RES     = 8,
  parameter int PRESC_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     en_out,
  input  logic [NUM_CH-1:0]     en_pwm,
  pwm_multi_channel_if.slave    wr_bus,
  input  logic [PRESC_W-1:0]    prescale,
  output logic                  period_start,
  output logic [NUM_CH-1:0]     out
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Counter runs 0..2^RES-2, giving a period of 2^RES-1 ticks so that a duty
  // of 2^RES-1 is a genuine constant high.
  localparam logic [RES-1:0] CNT_LAST = RES'((2 ** RES) - 2);

  logic [PRESC_W-1:0] presc_cnt;
  logic [RES-1:0]     cnt;
  logic               tick;
  logic               wrap;
  logic [RES-1:0]     pending [NUM_CH];
  logic [RES-1:0]     active  [NUM_CH];
  logic [NUM_CH-1:0]  pwm_raw;
  logic [NUM_CH-1:0]  out_next;

  // ">=" rather than "==" so lowering prescale below the running count
  // produces a tick on the very next cycle instead of a full roll-over.
  assign tick = (presc_cnt >= prescale);
  assign wrap = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (wrap) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + RES'(1);
      end
    end
  end

  // Matching each channel index individually means an out-of-range wr_ch
  // simply matches nothing and the write is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pending[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_bus.wr_en && (wr_bus.wr_ch == CH_W'(i))) begin
          pending[i] <= wr_bus.wr_duty;
        end
      end
    end
  end

  // Uses pending as held before this edge, so a write coincident with a wrap
  // is deferred to the following period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active[i] <= '0;
      end
    end else if (wrap) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active[i] <= pending[i];
      end
    end
  end

  always_comb begin
    pwm_raw  = '0;
    out_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_raw[i]  = (cnt < active[i]);
      out_next[i] = en_out[i] & (~en_pwm[i] | pwm_raw[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_next;
    end
  end
endmodule
